// File: rtl/controller_pkg.sv
// rtl/controller_pkg.sv - shared bus-condition state encoding
package controller_pkg;

  typedef enum logic [2:0] {
    BUS_UNKNOWN    = 3'd0,
    BUS_BUSY       = 3'd1,
    BUS_START_PEND = 3'd2,
    BUS_STOP_PEND  = 3'd3,
    BUS_POST_STOP  = 3'd4,
    BUS_FREE       = 3'd5,
    BUS_AVAIL      = 3'd6,
    BUS_IDLE       = 3'd7
  } bus_cond_state_e;

endpackage

// File: rtl/edge_detector.sv
// rtl/edge_detector.sv - pulses once a line has held its level for a programmed time after a trigger
module edge_detector #(
  parameter int unsigned CNTR_W         = 20,
  parameter bit          DETECT_NEGEDGE = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              trigger_i,
  input  logic              line_i,
  input  logic [CNTR_W-1:0] delay_count_i,
  output logic              detect_o
);

  logic              active_d, active_q;
  logic              det_d, det_q;
  logic [CNTR_W-1:0] count_d, count_q;
  logic              line_ok;
  logic              zero_delay;

  assign line_ok    = DETECT_NEGEDGE ? ~line_i : line_i;
  assign zero_delay = (delay_count_i == '0);

  always_comb begin
    active_d = active_q;
    count_d  = count_q;
    det_d    = 1'b0;
    if (trigger_i) begin
      // A zero delay is answered combinationally below; only longer delays arm the counter.
      active_d = ~zero_delay;
      count_d  = '0;
    end else if (active_q) begin
      if (!line_ok) begin
        active_d = 1'b0;
      end else if (count_q >= delay_count_i) begin
        det_d    = 1'b1;
        active_d = 1'b0;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q <= 1'b0;
      count_q  <= '0;
      det_q    <= 1'b0;
    end else begin
      active_q <= active_d;
      count_q  <= count_d;
      det_q    <= det_d;
    end
  end

  assign detect_o = det_q | (trigger_i & line_ok & zero_delay);

endmodule

// File: rtl/bus_condition_monitor.sv
// rtl/bus_condition_monitor.sv - classifies SCL/SDA into START/Sr/STOP and tracks the post-STOP bus ladder
module bus_condition_monitor
  import controller_pkg::*;
#(
  parameter int unsigned CNTR_W = 20
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              enable_i,
  input  logic              scl_i,
  input  logic              sda_i,
  input  logic [CNTR_W-1:0] t_cas_i,
  input  logic [CNTR_W-1:0] t_stop_i,
  input  logic [CNTR_W-1:0] t_free_i,
  input  logic [CNTR_W-1:0] t_avail_i,
  input  logic [CNTR_W-1:0] t_idle_i,
  output logic              start_det_o,
  output logic              rstart_det_o,
  output logic              stop_det_o,
  output logic              start_hold_err_o,
  output logic              bus_busy_o,
  output logic              bus_free_o,
  output logic              bus_available_o,
  output logic              bus_idle_o,
  output logic [2:0]        state_o
);

  logic scl_q, sda_q, scl_p, sda_p;
  logic start_trig, stop_trig, both_high;
  logic start_pulse, stop_pulse;

  bus_cond_state_e   state_d, state_q;
  logic [CNTR_W-1:0] cnt_d, cnt_q, cnt_inc;
  logic              rs_flag_d, rs_flag_q;
  logic              start_det_d, start_det_q;
  logic              rstart_det_d, rstart_det_q;
  logic              stop_det_d, stop_det_q;
  logic              hold_err_d, hold_err_q;

  // Lines reset high so a released bus does not look like an edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
      scl_p <= 1'b1;
      sda_p <= 1'b1;
    end else begin
      scl_q <= scl_i;
      sda_q <= sda_i;
      scl_p <= scl_q;
      sda_p <= sda_q;
    end
  end

  assign start_trig = enable_i & scl_q & scl_p & sda_p & ~sda_q;
  assign stop_trig  = enable_i & scl_q & scl_p & ~sda_p & sda_q;
  assign both_high  = scl_q & sda_q;
  assign cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  edge_detector #(.CNTR_W(CNTR_W), .DETECT_NEGEDGE(1'b0)) u_start_det (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .trigger_i     (start_trig),
    .line_i        (scl_q),
    .delay_count_i (t_cas_i),
    .detect_o      (start_pulse)
  );

  edge_detector #(.CNTR_W(CNTR_W), .DETECT_NEGEDGE(1'b0)) u_stop_det (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .trigger_i     (stop_trig),
    .line_i        (sda_q),
    .delay_count_i (t_stop_i),
    .detect_o      (stop_pulse)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rs_flag_d    = rs_flag_q;
    start_det_d  = 1'b0;
    rstart_det_d = 1'b0;
    stop_det_d   = 1'b0;
    hold_err_d   = 1'b0;
    if (!enable_i) begin
      state_d = BUS_UNKNOWN;
      cnt_d   = '0;
    end else if (start_trig) begin
      rs_flag_d = (state_q == BUS_BUSY) || (state_q == BUS_STOP_PEND);
      cnt_d     = '0;
      // With zero hold time the detector fires in the trigger cycle itself.
      if (start_pulse) begin
        state_d      = BUS_BUSY;
        rstart_det_d = rs_flag_d;
        start_det_d  = ~rs_flag_d;
      end else begin
        state_d = BUS_START_PEND;
      end
    end else begin
      unique case (state_q)
        BUS_UNKNOWN: begin
          if (!both_high) begin
            cnt_d = '0;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_q >= t_idle_i) state_d = BUS_IDLE;
          end
        end
        BUS_START_PEND: begin
          if (start_pulse) begin
            state_d      = BUS_BUSY;
            rstart_det_d = rs_flag_q;
            start_det_d  = ~rs_flag_q;
          end else if (!scl_q) begin
            state_d      = BUS_BUSY;
            rstart_det_d = rs_flag_q;
            start_det_d  = ~rs_flag_q;
            hold_err_d   = 1'b1;
          end else if (sda_q) begin
            state_d = rs_flag_q ? BUS_BUSY : BUS_UNKNOWN;
          end
        end
        BUS_BUSY: begin
          cnt_d = '0;
          if (stop_trig && stop_pulse) begin
            state_d    = BUS_POST_STOP;
            stop_det_d = 1'b1;
          end else if (stop_trig) begin
            state_d = BUS_STOP_PEND;
          end
        end
        BUS_STOP_PEND: begin
          if (stop_pulse) begin
            state_d    = BUS_POST_STOP;
            cnt_d      = '0;
            stop_det_d = 1'b1;
          end else if (!scl_q) begin
            state_d = BUS_BUSY;
          end
        end
        BUS_POST_STOP, BUS_FREE, BUS_AVAIL, BUS_IDLE: begin
          if (!both_high) begin
            state_d = BUS_BUSY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
            if (state_q == BUS_POST_STOP && cnt_q >= t_free_i)  state_d = BUS_FREE;
            if (state_q == BUS_FREE      && cnt_q >= t_avail_i) state_d = BUS_AVAIL;
            if (state_q == BUS_AVAIL     && cnt_q >= t_idle_i)  state_d = BUS_IDLE;
          end
        end
        default: state_d = BUS_UNKNOWN;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= BUS_UNKNOWN;
      cnt_q        <= '0;
      rs_flag_q    <= 1'b0;
      start_det_q  <= 1'b0;
      rstart_det_q <= 1'b0;
      stop_det_q   <= 1'b0;
      hold_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rs_flag_q    <= rs_flag_d;
      start_det_q  <= start_det_d;
      rstart_det_q <= rstart_det_d;
      stop_det_q   <= stop_det_d;
      hold_err_q   <= hold_err_d;
    end
  end

  assign start_det_o      = start_det_q;
  assign rstart_det_o     = rstart_det_q;
  assign stop_det_o       = stop_det_q;
  assign start_hold_err_o = hold_err_q;
  assign state_o          = state_q;

  assign bus_busy_o      = (state_q == BUS_BUSY) || (state_q == BUS_START_PEND) ||
                           (state_q == BUS_STOP_PEND);
  assign bus_free_o      = (state_q == BUS_FREE) || (state_q == BUS_AVAIL) || (state_q == BUS_IDLE);
  assign bus_available_o = (state_q == BUS_AVAIL) || (state_q == BUS_IDLE);
  assign bus_idle_o      = (state_q == BUS_IDLE);

endmodule
